// File: rtl/factorial_engine.sv
// Multi-cycle factorial engine: one shift-add multiply per MUL pass, one CHECK cycle per factor.
// Optional saturation on overflow is enabled by defining FACTORIAL_OVERFLOW_DETECT_EN.
module factorial_engine #(
  parameter int N_WIDTH    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_load,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PW = DATA_WIDTH + N_WIDTH;
  localparam int CW = $clog2(N_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, CHECK, DONE} state_t;

  state_t                state, state_nx;
  logic [N_WIDTH-1:0]    n_q, m_q;
  logic [N_WIDTH:0]      i_q, i_inc;
  logic [DATA_WIDTH-1:0] acc;
  logic [PW-1:0]         p_q;
  logic [CW-1:0]         bit_idx;
  logic                  ovf_hit, last_pass, mul_end;

  // i carries one extra bit so the final increment past 2^N_WIDTH-1 is representable
  assign i_inc     = i_q + 1'b1;
  assign last_pass = i_inc > {1'b0, n_q};
  assign mul_end   = bit_idx == CW'(N_WIDTH - 1);

`ifdef FACTORIAL_OVERFLOW_DETECT_EN
  logic ovf_q;
  assign ovf_hit  = |p_q[PW-1:DATA_WIDTH];
  assign overflow = ovf_q;
`else
  assign ovf_hit  = 1'b0;
  assign overflow = 1'b0;
`endif

  assign done        = state == DONE;
  assign result_load = state == DONE;
  assign busy        = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (n <= N_WIDTH'(1)) ? DONE : MUL;
      MUL:   if (mul_end) state_nx = CHECK;
      CHECK: state_nx = (ovf_hit || last_pass) ? DONE : MUL;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      m_q     <= '0;
      i_q     <= '0;
      acc     <= '0;
      p_q     <= '0;
      bit_idx <= '0;
      result  <= '0;
`ifdef FACTORIAL_OVERFLOW_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          n_q     <= n;
          acc     <= DATA_WIDTH'(1);
          i_q     <= (N_WIDTH+1)'(2);
          p_q     <= '0;
          m_q     <= N_WIDTH'(2);
          bit_idx <= '0;
`ifdef FACTORIAL_OVERFLOW_DETECT_EN
          ovf_q   <= 1'b0;
`endif
          // 0! and 1! skip the datapath entirely
          if (n <= N_WIDTH'(1)) result <= DATA_WIDTH'(1);
        end
        MUL: begin
          if (m_q[0]) p_q <= p_q + (PW'(acc) << bit_idx);
          m_q     <= m_q >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
        CHECK: begin
          acc     <= p_q[DATA_WIDTH-1:0];
          i_q     <= i_inc;
          p_q     <= '0;
          m_q     <= i_inc[N_WIDTH-1:0];
          bit_idx <= '0;
          if (ovf_hit) begin
            result <= '1;
`ifdef FACTORIAL_OVERFLOW_DETECT_EN
            ovf_q  <= 1'b1;
`endif
          end else if (last_pass) begin
            result <= p_q[DATA_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine; "done at edge k" means result_load is high in the
// cycle after edge k-1, so the downstream register captures on edge k (edge 0 = accepting edge).
module tb_factorial_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] n = '0;
  logic [7:0] result;
  logic       result_load, done, busy, overflow;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

`ifdef FACTORIAL_OVERFLOW_DETECT_EN
  localparam logic [7:0] R6   = 8'hFF;
  localparam logic       O6   = 1'b1;
  localparam logic [7:0] R15  = 8'hFF;
  localparam logic       O15  = 1'b1;
  localparam int         E15  = 26;
`else
  localparam logic [7:0] R6   = 8'd208;
  localparam logic       O6   = 1'b0;
  localparam logic [7:0] R15  = 8'd0;   // 15! has 2^11 as a factor
  localparam logic       O15  = 1'b0;
  localparam int         E15  = 71;
`endif

  factorial_engine #(.N_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .result(result),
    .result_load(result_load), .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge (edge 0); returns #1 after edge 0.
  task automatic accept(input logic [3:0] v);
    @(posedge clk); #1;
    start = 1'b1; n = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watch max_t cycles starting #1 after the current edge; optionally re-pulse start at edge rp_edge.
  task automatic observe(input int max_t, input int rp_edge, input logic [3:0] rp_n,
                         output int done_edge, output int loads, output int busy_cyc,
                         output int dl_diff, output logic [7:0] res, output logic ovf);
    done_edge = -1; loads = 0; busy_cyc = 0; dl_diff = 0; res = '0; ovf = 1'b0;
    for (int t = 0; t < max_t; t++) begin
      if (done) begin
        loads++;
        if (done_edge < 0) begin done_edge = t + 1; res = result; ovf = overflow; end
      end
      if (busy) busy_cyc++;
      if (done !== result_load) dl_diff++;
      if (t == rp_edge - 1) begin start = 1'b1; n = rp_n; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    chk_cnt++;
    if ({result, result_load, done, busy, overflow} !== 12'h0)
      $display("FAIL reset_outputs got=%h want=000", {result, result_load, done, busy, overflow});
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_small;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    for (int v = 0; v < 2; v++) begin
      accept(4'(v));
      observe(6, -1, 4'd0, de, ld, bc, dd, r, o);
      chk_cnt++;
      if (de !== 1) $display("FAIL n%0d_done_edge got=%0d want=1", v, de); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd1 || o !== 1'b0) $display("FAIL n%0d_result got=%0d/%b want=1/0", v, r, o);
      else pass_cnt++;
      chk_cnt++;
      if (ld !== 1) $display("FAIL n%0d_loads got=%0d want=1", v, ld); else pass_cnt++;
    end
  endtask

  task automatic test_n5;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    accept(4'd5);
    observe(26, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== 21) $display("FAIL n5_done_edge got=%0d want=21", de); else pass_cnt++;
    chk_cnt++;
    if (r !== 8'd120 || o !== 1'b0) $display("FAIL n5_result got=%0d/%b want=120/0", r, o);
    else pass_cnt++;
    chk_cnt++;
    if (bc !== 21) $display("FAIL n5_busy_cycles got=%0d want=21", bc); else pass_cnt++;
    chk_cnt++;
    if (dd !== 0 || ld !== 1) $display("FAIL n5_pulse diff=%0d loads=%0d want=0/1", dd, ld);
    else pass_cnt++;
  endtask

  task automatic test_n6;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    accept(4'd6);
    observe(30, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== 26) $display("FAIL n6_done_edge got=%0d want=26", de); else pass_cnt++;
    chk_cnt++;
    if (r !== R6 || o !== O6) $display("FAIL n6_result got=%h/%b want=%h/%b", r, o, R6, O6);
    else pass_cnt++;
    chk_cnt++;
    if (result !== R6 || overflow !== O6)
      $display("FAIL n6_hold got=%h/%b want=%h/%b", result, overflow, R6, O6);
    else pass_cnt++;
  endtask

  task automatic test_n15_then_3;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    accept(4'd15);
    observe(E15 + 4, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== E15) $display("FAIL n15_done_edge got=%0d want=%0d", de, E15); else pass_cnt++;
    chk_cnt++;
    if (r !== R15 || o !== O15) $display("FAIL n15_result got=%h/%b want=%h/%b", r, o, R15, O15);
    else pass_cnt++;
    accept(4'd3);
    observe(14, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== 11) $display("FAIL n3_done_edge got=%0d want=11", de); else pass_cnt++;
    chk_cnt++;
    if (r !== 8'd6 || o !== 1'b0) $display("FAIL n3_result got=%0d/%b want=6/0", r, o);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    accept(4'd4);
    observe(30, 3, 4'd2, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== 16) $display("FAIL busy_start_done_edge got=%0d want=16", de); else pass_cnt++;
    chk_cnt++;
    if (r !== 8'd24) $display("FAIL busy_start_result got=%0d want=24", r); else pass_cnt++;
    chk_cnt++;
    if (ld !== 1) $display("FAIL busy_start_loads got=%0d want=1", ld); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int de, ld, bc, dd; logic [7:0] r; logic o;
    accept(4'd5);
    observe(10, -1, 4'd0, de, ld, bc, dd, r, o);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({result, result_load, done, busy, overflow} !== 12'h0)
      $display("FAIL midreset_outputs got=%h want=000", {result, result_load, done, busy, overflow});
    else pass_cnt++;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    observe(30, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (ld !== 0 || bc !== 0) $display("FAIL midreset_quiet loads=%0d busy=%0d want=0/0", ld, bc);
    else pass_cnt++;
    accept(4'd3);
    observe(14, -1, 4'd0, de, ld, bc, dd, r, o);
    chk_cnt++;
    if (de !== 11 || r !== 8'd6)
      $display("FAIL midreset_n3 edge=%0d result=%0d want=11/6", de, r);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_small;
    test_n5;
    test_n6;
    test_n15_then_3;
    test_ignore_start;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
